// File: rtl/syscon_wb_arbiter.sv
// syscon_wb_arbiter: round-robin two-master Wishbone arbiter with a watchdog on the syscon slave port
module syscon_wb_arbiter #(
  parameter int dw = 32,
  parameter int aw = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [aw-1:0] m0_adr_i,
  input  logic [dw-1:0] m0_dat_i,
  input  logic [3:0]    m0_sel_i,
  output logic [dw-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  output logic          m0_rty_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [aw-1:0] m1_adr_i,
  input  logic [dw-1:0] m1_dat_i,
  input  logic [3:0]    m1_sel_i,
  output logic [dw-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic          m1_rty_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [aw-1:0] s_adr_o,
  output logic [dw-1:0] s_dat_o,
  output logic [3:0]    s_sel_o,
  input  logic [dw-1:0] s_dat_i,
  input  logic          s_ack_i,
  input  logic          s_err_i,
  input  logic          s_rty_i
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t state;
  logic last_grant, to_err, g0, g1, stall;
  logic [CW-1:0] cnt;
  always_comb begin
    g0 = state == GNT0;
    g1 = state == GNT1;
    s_cyc_o = g0 ? m0_cyc_i : g1 ? m1_cyc_i : 1'b0;
    s_stb_o = (g0 ? m0_stb_i : g1 ? m1_stb_i : 1'b0) & ~to_err;
    s_we_o = g0 ? m0_we_i : g1 ? m1_we_i : 1'b0;
    s_adr_o = g0 ? m0_adr_i : g1 ? m1_adr_i : '0;
    s_dat_o = g0 ? m0_dat_i : g1 ? m1_dat_i : '0;
    s_sel_o = g0 ? m0_sel_i : g1 ? m1_sel_i : '0;
    m0_dat_o = g0 ? s_dat_i : '0;
    m0_ack_o = g0 & s_ack_i;
    m0_err_o = g0 & (s_err_i | to_err);
    m0_rty_o = g0 & s_rty_i;
    m1_dat_o = g1 ? s_dat_i : '0;
    m1_ack_o = g1 & s_ack_i;
    m1_err_o = g1 & (s_err_i | to_err);
    m1_rty_o = g1 & s_rty_i;
    stall = s_cyc_o & s_stb_o & ~(s_ack_i | s_err_i | s_rty_i);
  end
  // Grant is held for the whole cycle; dropping cyc always passes through IDLE
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state <= IDLE;
      last_grant <= 1'b1;
      cnt <= '0;
      to_err <= 1'b0;
    end else begin
      to_err <= 1'b0;
      if (state == IDLE) begin
        cnt <= '0;
        if (m0_cyc_i & (~m1_cyc_i | last_grant)) begin
          state <= GNT0;
          last_grant <= 1'b0;
        end else if (m1_cyc_i) begin
          state <= GNT1;
          last_grant <= 1'b1;
        end
      end else if (!s_cyc_o) begin
        state <= IDLE;
        cnt <= '0;
      end else if (stall) begin
        to_err <= cnt == LIM;
        cnt <= cnt == LIM ? '0 : cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule
